fifo_reader: RTL

FIFO_READER -- requirements
Module: fifo_reader

---
 rtl/fifo_reader_if.sv | 22 ++
 rtl/fifo_reader.sv | 89 ++++++++
 2 files changed

// File: rtl/fifo_reader_if.sv
// Handshake bundle between a FIFO core, the fifo_reader skid buffer and its downstream consumer.
// The slave modport is the fifo_reader side; the master modport is the surrounding environment.
interface fifo_reader_if #(
  parameter int DATA_W = 8
);
  logic              fifo_empty;
  logic [DATA_W-1:0] fifo_data;
  logic              fifo_rd_en;
  logic              m_valid;
  logic              m_ready;
  logic [DATA_W-1:0] m_data;

  modport master (
    output fifo_empty, fifo_data, m_ready,
    input  fifo_rd_en, m_valid, m_data
  );

  modport slave (
    input  fifo_empty, fifo_data, m_ready,
    output fifo_rd_en, m_valid, m_data
  );
endinterface

// File: rtl/fifo_reader.sv
// Pops a 1-cycle-latency FIFO core into a 2-entry in-order skid buffer feeding a valid/ready sink.
// Optional popped-word counter output pop_cnt is enabled by defining FIFO_READER_CNT_EN.
module fifo_reader #(
  parameter int DATA_W = 8
) (
  input  logic         clk,
  input  logic         rst,
`ifdef FIFO_READER_CNT_EN
  output logic [15:0]  pop_cnt,
`endif
  fifo_reader_if.slave bus
);

  logic [1:0]        occ_q, occ_d;
  logic              infl_q, infl_d;
  logic              wr_idx_q, wr_idx_d;
  logic              rd_idx_q, rd_idx_d;
  logic [DATA_W-1:0] mem_q [2];
  logic [DATA_W-1:0] mem_d [2];

  logic              valid;
  logic              pop;
  logic              rd_en;
  logic [1:0]        credit;

  // credit is the occupancy after this edge, before any new request lands; it never exceeds 2
  // because a request is only issued while it is below 2, and pop implies occ_q >= 1.
  always_comb begin
    valid  = (occ_q != 2'd0);
    pop    = valid & bus.m_ready;
    credit = occ_q + {1'b0, infl_q} - {1'b0, pop};
    rd_en  = ~bus.fifo_empty & ~rst & (credit < 2'd2);
  end

  // NOTE: every variable written in this block gets a default first, so no latch is inferred.
  always_comb begin
    occ_d    = credit;
    infl_d   = rd_en;
    wr_idx_d = wr_idx_q;
    rd_idx_d = rd_idx_q;
    mem_d    = mem_q;
    if (infl_q) begin
      mem_d[wr_idx_q] = bus.fifo_data;
      wr_idx_d        = ~wr_idx_q;
    end
    if (pop) begin
      rd_idx_d = ~rd_idx_q;
    end
  end

  // NOTE: state uses non-blocking assignments; the two storage words are reset too so m_data
  // reads 0 while in reset rather than stale payload.
  always_ff @(posedge clk) begin
    if (rst) begin
      occ_q    <= 2'd0;
      infl_q   <= 1'b0;
      wr_idx_q <= 1'b0;
      rd_idx_q <= 1'b0;
      mem_q[0] <= '0;
      mem_q[1] <= '0;
    end else begin
      occ_q    <= occ_d;
      infl_q   <= infl_d;
      wr_idx_q <= wr_idx_d;
      rd_idx_q <= rd_idx_d;
      mem_q    <= mem_d;
    end
  end

  assign bus.fifo_rd_en = rd_en;
  assign bus.m_valid    = valid;
  assign bus.m_data     = mem_q[rd_idx_q];

`ifdef FIFO_READER_CNT_EN
  logic [15:0] pop_cnt_q, pop_cnt_d;

  always_comb begin
    pop_cnt_d = pop_cnt_q + {15'd0, pop};
  end

  always_ff @(posedge clk) begin
    if (rst) pop_cnt_q <= 16'd0;
    else     pop_cnt_q <= pop_cnt_d;
  end

  assign pop_cnt = pop_cnt_q;
`endif

endmodule
